divu_iter: RTL and testbench
============================

Name: divu_iter

Overview:
Multi-cycle iterative restoring divider for the lab RV32 datapath. It implements DIV, DIVU, REM and REMU. It sits directly downstream of the unsigned set-less-than comparator: each iteration issues one unsigned compare of partial remainder against divisor, and that compare selects subtract or keep. The ALU issues an operation with a start pulse and collects the result on a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand and result width in bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  single rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new division; honoured only when busy=0
- is_signed  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU
- dividend  input  WIDTH  numerator, sampled on the accepting edge
- divisor  input  WIDTH  denominator, sampled on the accepting edge
- busy  output  1  high from the accepting edge until done is asserted
- done  output  1  one-cycle pulse; quotient and remainder are valid
- quotient  output  WIDTH  registered quotient, held until the next accepted start
- remainder  output  WIDTH  registered remainder, held until the next accepted start

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0.
  - Internal counter and shift registers are cleared.
  - An in-flight operation is discarded without producing done.
- FSM states:
  - IDLE: wait for start.
  - CALC: one restoring step per cycle.
  - FINISH: sign fix-up and output load.
- IDLE with start=1 (the accepting edge):
  - Latch |dividend| and |divisor|. Take absolute values only when is_signed=1; otherwise use the operands unchanged.
  - Latch neg_q = is_signed & (dividend[MSB] ^ divisor[MSB]).
  - Latch neg_r = is_signed & dividend[MSB].
  - Clear the partial remainder and the counter; assert busy; go to CALC.
  - Exception: if divisor==0, go straight to FINISH with the div-zero flag set.
- CALC step:
  - Shift {rem, dvd} left by 1.
  - If the shifted rem is not less than the divisor (unsigned compare), subtract the divisor from rem and set quotient bit 0 to 1; otherwise set it to 0.
  - rem is WIDTH+1 bits wide internally so the compare has no overflow.
  - Stay in CALC for exactly WIDTH cycles (counter 0..WIDTH-1), then go to FINISH.
- FINISH:
  - quotient = neg_q ? -q : q. remainder = neg_r ? -rem : rem.
  - done=1 for one cycle; busy=0; go to IDLE.
- Division by zero (RISC-V semantics): quotient = all ones; remainder = the original dividend, not the absolute value.
- Signed overflow, -2^(WIDTH-1) / -1: quotient = 0x80000000, remainder = 0. The algorithm produces this naturally; no special case is needed.
- Latency, counting the accepting edge as edge 0:
  - Normal operation: done is high after edge WIDTH+1 (edge 33 for WIDTH=32).
  - Divide by zero: done is high after edge 1.
- Handshake rules:
  - start while busy=1 is ignored, with no effect on the running operation.
  - start in the same cycle that done is high is accepted: the FSM is in IDLE at the next edge, so that edge is the accepting edge.
  - Operand inputs are don't-care except on the accepting edge.
- Outputs change only on the FINISH edge and on reset.

Decomposition:
- Shared package (div_pkg):
  - WIDTH default.
  - FSM state enum: IDLE, CALC, FINISH.
  - Counter width constant, $clog2(WIDTH).
- Sub-module div_step:
  - Combinational; one restoring iteration.
  - Inputs: rem, dvd_msb, divisor.
  - Outputs: next_rem, q_bit.
  - Contains the unsigned less-than compare, so it can be unit-tested against the existing comparator vectors.

Test Plan:
- Unsigned divide: is_signed=0, 100 / 7 → quotient=14, remainder=2. done is high 33 cycles after the accepting edge; busy is high throughout.
- Unsigned large values: 0xFFFFFFFF / 0x00000001 → quotient=0xFFFFFFFF, remainder=0. Then 0x00000001 / 0xFFFFFFFF → quotient=0, remainder=1.
- Signed signs, with is_signed=1:
  - -7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - 7 / -2 → quotient=0xFFFFFFFD, remainder=1.
  - 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Divide by zero: 0x12345678 / 0 with both is_signed=0 and is_signed=1 → quotient=0xFFFFFFFF, remainder=0x12345678. done is high after edge 1.
- start while busy: pulse start with different operands in cycle 10 of a 100/7 operation → result is still 14/2 with unchanged timing. start held high in the done cycle launches the next operation immediately.
- Reset mid-operation: assert rst in cycle 15 of a divide → busy, done and both outputs are 0 at once, asynchronously. After release, a new 50/5 operation returns quotient=10, remainder=0.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared width default, counter width and FSM encoding for the iterative divider.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int CNT_W = $clog2(DIV_WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration built around an unsigned less-than compare.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic             q_bit
);
    logic [WIDTH:0] sh;
    logic lt;
    // rem[WIDTH] set would make the shifted value exceed any divisor, so it only gates lt
    always_comb begin
        sh       = {rem[WIDTH-1:0], dvd_msb};
        lt       = ~rem[WIDTH] & (sh < {1'b0, divisor});
        q_bit    = ~lt;
        next_rem = lt ? sh : sh - {1'b0, divisor};
    end
endmodule

// File: rtl/divu_iter.sv
// divu_iter: multi-cycle restoring divider for DIV/DIVU/REM/REMU with RISC-V divide-by-zero results.
module divu_iter import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = (WIDTH == DIV_WIDTH) ? CNT_W : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH:0] rem_q, rem_d, step_rem;
    logic [WIDTH-1:0] dvd_q, dvd_d, dsr_q, dsr_d, quo_q, quo_d, rmd_q, rmd_d;
    logic negq_q, negq_d, negr_q, negr_d, dz_q, dz_d, done_q, done_d;
    logic step_q, sign_a, sign_b;

    assign sign_a = is_signed & dividend[WIDTH-1];
    assign sign_b = is_signed & divisor[WIDTH-1];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem(rem_q),
        .dvd_msb(dvd_q[WIDTH-1]),
        .divisor(dsr_q),
        .next_rem(step_rem),
        .q_bit(step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    // dvd_q shifts the dividend out at the top and collects quotient bits at the bottom
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                dz_d    = divisor == '0;
                dvd_d   = (sign_a && !dz_d) ? -dividend : dividend;
                dsr_d   = sign_b ? -divisor : divisor;
                negq_d  = sign_a ^ sign_b;
                negr_d  = sign_a;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = dz_d ? FINISH : CALC;
            end
            CALC: begin
                rem_d   = step_rem;
                dvd_d   = {dvd_q[WIDTH-2:0], step_q};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST) ? FINISH : CALC;
            end
            FINISH: begin
                quo_d   = dz_q ? '1 : negq_q ? -dvd_q : dvd_q;
                rmd_d   = dz_q ? dvd_q : negr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q != IDLE;
        done      = done_q;
        quotient  = quo_q;
        remainder = rmd_q;
    end
endmodule

// File: tb/tb_divu_iter.sv
// tb_divu_iter: directed and randomized checks of divu_iter against an arithmetic reference model.
module tb_divu_iter;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst, start, is_signed, busy, done;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    divu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder)
    );

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint sa, sb;
        logic [W-1:0] q, r;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q = W'(sa / sb);
            r = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output int lat, output logic busy_ok);
        @(negedge clk);
        dividend = a;
        divisor = b;
        is_signed = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 100) begin
            @(posedge clk);
            #1 lat++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        q = quotient;
        r = remainder;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        dividend = '0;
        divisor = '0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
        checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [9] = '{32'd100, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF9, 32'd7,
                                 32'h80000000, 32'h12345678, 32'h12345678, 32'hFFFFFFF9};
        logic [W-1:0] tb [9] = '{32'd7, 32'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE,
                                 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
        logic ts [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] eq [9] = '{32'd14, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFD, 32'hFFFFFFFD,
                                 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [W-1:0] er [9] = '{32'd2, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd1,
                                 32'd0, 32'h12345678, 32'h12345678, 32'hFFFFFFF9};
        logic [W-1:0] q, r;
        int lat, exp_lat;
        logic bok;
        for (int i = 0; i < 9; i++) begin
            run_op(ta[i], tb[i], ts[i], q, r, lat, bok);
            exp_lat = (tb[i] == '0) ? 1 : W + 1;
            checks++; if (q !== eq[i]) begin errors++; $display("FAIL dir%0d_quotient got=%h exp=%h", i, q, eq[i]); end
            checks++; if (r !== er[i]) begin errors++; $display("FAIL dir%0d_remainder got=%h exp=%h", i, r, er[i]); end
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
            checks++; if (bok !== 1'b1) begin errors++; $display("FAIL dir%0d_busy got=dropped exp=held", i); end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, q, r;
        logic [2*W-1:0] m;
        logic s, bok;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = '1;
                2, 3: b = W'($urandom_range(1, 20));
                4: b = {1'b1, W'($urandom_range(0, 255)) >> 1};
                default: b = $urandom;
            endcase
            if (i % 10 == 9) a = 32'h80000000;
            m = model(a, b, s);
            run_op(a, b, s, q, r, lat, bok);
            checks++; if (q !== m[2*W-1:W]) begin errors++; $display("FAIL rnd%0d_quotient a=%h b=%h s=%b got=%h exp=%h", i, a, b, s, q, m[2*W-1:W]); end
            checks++; if (r !== m[W-1:0]) begin errors++; $display("FAIL rnd%0d_remainder a=%h b=%h s=%b got=%h exp=%h", i, a, b, s, r, m[W-1:0]); end
            checks++; if (lat != ((b == '0) ? 1 : W + 1)) begin errors++; $display("FAIL rnd%0d_latency got=%0d", i, lat); end
        end
    endtask

    task automatic test_start_while_busy;
        int lat;
        @(negedge clk);
        dividend = 32'd100;
        divisor = 32'd7;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1 lat++;
            if (done) break;
            start = (lat == 9);
            if (lat == 9) begin
                dividend = 32'd55;
                divisor = 32'd3;
                is_signed = 1'b1;
            end
        end
        start = 1'b0;
        checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL busy_start_quotient got=%0d exp=14", quotient); end
        checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL busy_start_remainder got=%0d exp=2", remainder); end
        checks++; if (lat != W + 1) begin errors++; $display("FAIL busy_start_latency got=%0d exp=%0d", lat, W + 1); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        dividend = 32'd1000;
        divisor = 32'd9;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 dividend = 32'd77;
        divisor = 32'd5;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1 lat++;
            if (done) break;
        end
        checks++; if (quotient !== 32'd111) begin errors++; $display("FAIL b2b_first_quotient got=%0d exp=111", quotient); end
        checks++; if (remainder !== 32'd1) begin errors++; $display("FAIL b2b_first_remainder got=%0d exp=1", remainder); end
        checks++; if (lat != W + 1) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, W + 1); end
        @(posedge clk);
        #1 start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1 lat++;
            if (done) break;
        end
        checks++; if (quotient !== 32'd15) begin errors++; $display("FAIL b2b_second_quotient got=%0d exp=15", quotient); end
        checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL b2b_second_remainder got=%0d exp=2", remainder); end
        checks++; if (lat != W + 1) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, W + 1); end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] q, r;
        int lat;
        logic bok;
        @(negedge clk);
        dividend = 32'd100;
        divisor = 32'd7;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (quotient !== '0) begin errors++; $display("FAIL midrst_quotient got=%h exp=0", quotient); end
        checks++; if (remainder !== '0) begin errors++; $display("FAIL midrst_remainder got=%h exp=0", remainder); end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_discard done=%b busy=%b exp=0/0", done, busy); end
        run_op(32'd50, 32'd5, 1'b0, q, r, lat, bok);
        checks++; if (q !== 32'd10) begin errors++; $display("FAIL midrst_after_quotient got=%0d exp=10", q); end
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL midrst_after_remainder got=%0d exp=0", r); end
        checks++; if (lat != W + 1) begin errors++; $display("FAIL midrst_after_latency got=%0d exp=%0d", lat, W + 1); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
